// File: rtl/multicycle_core_if.sv
// Instruction handshake bundle between the instruction source and the core.
//   instr_valid  source -> core   instr holds a valid instruction
//   instr_ready  core -> source   core accepts instr in this cycle
//   instr        source -> core   {codop[3:0], addA, addB_LMM, addC}
interface multicycle_core_if #(
   parameter int INSTR_W = 20
);
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;

   modport master (output instr_valid, output instr, input instr_ready);
   modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle execution core: phase sequencer, register file and ALU on one clock.
// Instructions arrive on the bus handshake; in step mode every stage advance
// waits for a step pulse.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   bus (slave)         instr_valid / instr_ready / instr
//   step_mode, step     single-step control
//   stage               one-hot {EXEC,DECODE,WB}, 000 = IDLE
//   dbg_a, dbg_b        operand latches
//   dbg_out             ALU result latch
//   flag_neg/zero/ovf   status flags (updated in EXEC)
//   retire, illegal     one-cycle pulses in the WB cycle
//   dbg_rd_addr/data    combinational register-file read
//
// state  | meaning
// IDLE   | waiting for a valid instruction
// DECODE | operands latched from the register file on advance
// EXEC   | ALU result and flags latched on advance
// WB     | result written to addC on advance, retire pulse
module multicycle_core #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16,
   parameter int IMM_W  = 8,
   localparam int AW      = $clog2(NREGS),
   localparam int INSTR_W = 4 + 2*AW + IMM_W
) (
   input  logic                clk,
   input  logic                rst_n,
   multicycle_core_if.slave    bus,
   input  logic                step_mode,
   input  logic                step,
   output logic [2:0]          stage,
   output logic [DATA_W-1:0]   dbg_a,
   output logic [DATA_W-1:0]   dbg_b,
   output logic [DATA_W-1:0]   dbg_out,
   output logic                flag_neg,
   output logic                flag_zero,
   output logic                flag_ovf,
   output logic                retire,
   output logic                illegal,
   input  logic [AW-1:0]       dbg_rd_addr,
   output logic [DATA_W-1:0]   dbg_rd_data
);
   localparam int SH_W = $clog2(DATA_W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DEC  = 2'd1;
   localparam logic [1:0] S_EXE  = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, out_q, out_d;
   logic               neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d;
   logic [DATA_W-1:0]  regs_q [NREGS];
   logic [DATA_W-1:0]  regs_d [NREGS];

   logic [INSTR_W-1:0] instr_in;
   logic [3:0]         op;
   logic [AW-1:0]      add_a, add_c;
   logic [IMM_W-1:0]   imm;
   logic               adv, ready;

   logic [DATA_W-1:0]  alu_r, imm_ext;
   logic               alu_ovf, alu_wr;

   assign instr_in = bus.instr;
   assign op       = instr_q[INSTR_W-1 -: 4];
   assign add_a    = instr_q[AW+IMM_W +: AW];
   assign imm      = instr_q[AW +: IMM_W];
   assign add_c    = instr_q[0 +: AW];

   // adv is combinational so a step coinciding with a step_mode change uses the new mode
   assign adv   = !step_mode | step;
   assign ready = (state_q == S_IDLE) & adv;

   always_comb begin
      imm_ext = '0;
      imm_ext[IMM_W-1:0] = imm;
      alu_r   = a_q;
      alu_ovf = 1'b0;
      alu_wr  = (op <= 4'd9);
      case (op)
         4'd0: begin
            alu_r   = a_q + b_q;
            alu_ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_r[DATA_W-1] != a_q[DATA_W-1]);
         end
         4'd1: begin
            alu_r   = a_q - b_q;
            alu_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_r[DATA_W-1] != a_q[DATA_W-1]);
         end
         4'd2:    alu_r = a_q & b_q;
         4'd3:    alu_r = a_q | b_q;
         4'd4:    alu_r = a_q ^ b_q;
         4'd5:    alu_r = ~a_q;
         4'd6:    alu_r = a_q << b_q[SH_W-1:0];
         4'd7:    alu_r = a_q >> b_q[SH_W-1:0];
         4'd8:    alu_r = imm_ext;
         default: alu_r = a_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      a_d     = a_q;
      b_d     = b_q;
      out_d   = out_q;
      neg_d   = neg_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      regs_d  = regs_q;
      case (state_q)
         S_IDLE: if (bus.instr_valid && ready) begin
            instr_d = instr_in;
            state_d = S_DEC;
         end
         S_DEC: if (adv) begin
            a_d     = regs_q[add_a];
            b_d     = regs_q[imm[AW-1:0]];
            state_d = S_EXE;
         end
         S_EXE: if (adv) begin
            // NOP and undefined opcodes leave result latch and flags untouched
            if (alu_wr) begin
               out_d  = alu_r;
               neg_d  = alu_r[DATA_W-1];
               zero_d = (alu_r == '0);
               ovf_d  = alu_ovf;
            end
            state_d = S_WB;
         end
         S_WB: if (adv) begin
            if (alu_wr) regs_d[add_c] = out_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         neg_q   <= neg_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         regs_q  <= regs_d;
      end
   end

   assign bus.instr_ready = ready;
   assign stage       = {state_q == S_EXE, state_q == S_DEC, state_q == S_WB};
   assign dbg_a       = a_q;
   assign dbg_b       = b_q;
   assign dbg_out     = out_q;
   assign flag_neg    = neg_q;
   assign flag_zero   = zero_q;
   assign flag_ovf    = ovf_q;
   // retire only on the WB cycle that actually leaves WB, so a stalled WB pulses once
   assign retire      = (state_q == S_WB) & adv;
   assign illegal     = retire & (op >= 4'd11);
   // reads the flops, so a WB write becomes visible the cycle after WB
   assign dbg_rd_data = regs_q[dbg_rd_addr];
endmodule

// File: tb/tb_multicycle_core.sv
module tb_multicycle_core;
   localparam int DATA_W  = 16;
   localparam int NREGS   = 16;
   localparam int IMM_W   = 8;
   localparam int AW      = 4;
   localparam int INSTR_W = 4 + 2*AW + IMM_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              step_mode = 1'b0;
   logic              step = 1'b0;
   logic [2:0]        stage;
   logic [DATA_W-1:0] dbg_a, dbg_b, dbg_out, dbg_rd_data;
   logic              flag_neg, flag_zero, flag_ovf, retire, illegal;
   logic [AW-1:0]     dbg_rd_addr = '0;

   multicycle_core_if #(.INSTR_W(INSTR_W)) bus ();

   multicycle_core #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .step_mode(step_mode), .step(step),
      .stage(stage), .dbg_a(dbg_a), .dbg_b(dbg_b), .dbg_out(dbg_out),
      .flag_neg(flag_neg), .flag_zero(flag_zero), .flag_ovf(flag_ovf),
      .retire(retire), .illegal(illegal),
      .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
   );

   always #5 clk = ~clk;

   int retire_cnt = 0;
   always @(posedge clk) if (rst_n && retire) retire_cnt <= retire_cnt + 1;

   // reference model state
   logic [15:0] m_regs [16];
   logic [15:0] m_out;
   logic        m_neg, m_zero, m_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int sval(input logic [15:0] v);
      return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
   endfunction

   function automatic void model_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic [7:0] imm, output logic [15:0] r, output logic ov);
      int s;
      r  = a;
      ov = 1'b0;
      case (op)
         4'd0: begin s = sval(a) + sval(b); r = 16'(int'(a) + int'(b)); ov = (s > 32767) || (s < -32768); end
         4'd1: begin s = sval(a) - sval(b); r = 16'(int'(a) - int'(b)); ov = (s > 32767) || (s < -32768); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~a;
         4'd6: r = 16'(int'(a) * (2 ** int'(b % 16)));
         4'd7: r = 16'(int'(a) / (2 ** int'(b % 16)));
         4'd8: r = {8'h00, imm};
         default: r = a;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_out = '0; m_neg = 0; m_zero = 0; m_ovf = 0;
   endtask

   task automatic check_flags(input string tag);
      chk({tag, "_neg"},  32'(flag_neg),  32'(m_neg));
      chk({tag, "_zero"}, 32'(flag_zero), 32'(m_zero));
      chk({tag, "_ovf"},  32'(flag_ovf),  32'(m_ovf));
   endtask

   task automatic rd(input logic [3:0] r, input logic [15:0] exp, input string tag);
      dbg_rd_addr = r;
      #1;
      chk(tag, 32'(dbg_rd_data), 32'(exp));
   endtask

   // free-running instruction: called with the core IDLE, returns at an IDLE negedge
   task automatic run(input logic [3:0] op, input logic [3:0] ra, input logic [7:0] imm, input logic [3:0] rc);
      logic [15:0] a, b, r;
      logic        ov, wr;
      int          n;
      a  = m_regs[ra];
      b  = m_regs[imm[3:0]];
      wr = (op <= 4'd9);
      model_alu(op, a, b, imm, r, ov);
      bus.instr = {op, ra, imm, rc};
      bus.instr_valid = 1'b1;
      #1;
      n = 0;
      while (bus.instr_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      chk("accept_ready", 32'(bus.instr_ready), 1);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr = INSTR_W'($urandom);
      #1;
      chk("stage_decode", 32'(stage), 'b010);
      chk("ready_busy", 32'(bus.instr_ready), 0);
      chk("retire_dec", 32'(retire), 0);
      @(negedge clk);
      dbg_rd_addr = rc;
      #1;
      chk("stage_exec", 32'(stage), 'b100);
      chk("dbg_a", 32'(dbg_a), 32'(a));
      chk("dbg_b", 32'(dbg_b), 32'(b));
      @(negedge clk);
      #1;
      chk("stage_wb", 32'(stage), 'b001);
      chk("retire_wb", 32'(retire), 1);
      chk("illegal_wb", 32'(illegal), 32'(op >= 4'd11));
      chk("dbg_rd_old", 32'(dbg_rd_data), 32'(m_regs[rc]));
      if (wr) begin
         m_out = r; m_ovf = ov; m_neg = (r >= 16'h8000); m_zero = (r == 16'h0000);
         m_regs[rc] = r;
         chk("dbg_out", 32'(dbg_out), 32'(r));
      end
      check_flags("flags");
      @(negedge clk);
      #1;
      chk("stage_idle", 32'(stage), 'b000);
      chk("dbg_rd_new", 32'(dbg_rd_data), 32'(m_regs[rc]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int rc0;
      logic [2:0] walk [4];
      walk[0] = 3'b010; walk[1] = 3'b100; walk[2] = 3'b001; walk[3] = 3'b000;
      model_reset();
      bus.instr = '0;
      bus.instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stage", 32'(stage), 0);
      chk("rst_ready", 32'(bus.instr_ready), 1);
      chk("rst_retire", 32'(retire), 0);
      chk("rst_dbg_out", 32'(dbg_out), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_flags("rst_flags");
      rd(4'd5, 16'h0, "rst_reg5");

      // 1: LMM/LMM/ADD
      run(4'd8, 4'd0, 8'h7F, 4'd1);
      run(4'd8, 4'd0, 8'h01, 4'd2);
      run(4'd0, 4'd1, 8'h02, 4'd3);
      rd(4'd3, 16'h0080, "t1_r3");
      chk("t1_neg_zero_ovf", {29'd0, flag_neg, flag_zero, flag_ovf}, 0);

      // 2: build 0x7FFF, overflow add, self subtract
      run(4'd8, 4'd0, 8'h01, 4'd1);
      run(4'd8, 4'd0, 8'h7F, 4'd4);
      run(4'd8, 4'd0, 8'h08, 4'd9);
      run(4'd6, 4'd4, 8'h09, 4'd4);
      run(4'd8, 4'd0, 8'hFF, 4'd10);
      run(4'd3, 4'd4, 8'h0A, 4'd4);
      rd(4'd4, 16'h7FFF, "t2_r4");
      run(4'd0, 4'd4, 8'h01, 4'd5);
      rd(4'd5, 16'h8000, "t2_r5");
      chk("t2_ovf_neg", {30'd0, flag_ovf, flag_neg}, 'b11);
      run(4'd1, 4'd5, 8'h05, 4'd6);
      chk("t2_zero_ovf", {30'd0, flag_zero, flag_ovf}, 'b10);

      // 3: single-step walk
      step_mode = 1'b1;
      bus.instr = {4'd8, 4'd0, 8'h33, 4'd8};
      bus.instr_valid = 1'b1;
      #1;
      chk("step_ready_low", 32'(bus.instr_ready), 0);
      repeat (5) @(negedge clk);
      #1;
      chk("step_no_accept", 32'(stage), 0);
      rc0 = retire_cnt;
      for (int k = 0; k < 4; k++) begin
         step = 1'b1;
         #1;
         if (k == 3) chk("step_retire", 32'(retire), 1);
         @(negedge clk);
         step = 1'b0;
         #1;
         chk("step_walk", 32'(stage), 32'(walk[k]));
         repeat (4) @(negedge clk);
         #1;
         chk("step_hold", 32'(stage), 32'(walk[k]));
         chk("step_hold_retire", 32'(retire), 0);
      end
      chk("step_one_retire", 32'(retire_cnt - rc0), 1);
      bus.instr_valid = 1'b0;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      #1;
      chk("step_idle_ignored", 32'(stage), 0);
      step_mode = 1'b0;
      m_regs[8] = 16'h0033; m_out = 16'h0033; m_neg = 0; m_zero = 0; m_ovf = 0;
      rd(4'd8, 16'h0033, "t3_r8");
      check_flags("t3_flags");

      // 4: back-to-back dependent ops
      run(4'd8, 4'd0, 8'h05, 4'd7);
      run(4'd0, 4'd7, 8'h07, 4'd7);
      run(4'd0, 4'd7, 8'h07, 4'd7);
      rd(4'd7, 16'd20, "t4_r7");

      // 5: undefined opcode
      run(4'd12, 4'd3, 8'h44, 4'd1);
      rd(4'd1, 16'h0001, "t5_r1");

      // 6: reset during EXEC
      dbg_rd_addr = 4'd2;
      rc0 = retire_cnt;
      bus.instr = {4'd0, 4'd1, 8'h01, 4'd2};
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("t6_in_exec", 32'(stage), 'b100);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_stage", 32'(stage), 0);
      chk("t6_retire", 32'(retire), 0);
      chk("t6_r2", 32'(dbg_rd_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_no_retire", 32'(retire_cnt - rc0), 0);
      check_flags("t6_flags");
      run(4'd8, 4'd0, 8'h2A, 4'd2);
      rd(4'd2, 16'h002A, "t6_after");

      // randomized instructions against the model
      for (int i = 0; i < 40; i++)
         run(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom), 4'($urandom_range(0, 15)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
